gaussian_row_scheduler: RTL and testbench
=========================================

# gaussian_row_scheduler

Read-side controller for the Gaussian stage FIFO that sits between the down sampler and the up sampler. Tracks FIFO occupancy from the write strobes, waits until one full image row is buffered, then issues a row-length burst of FIFO reads paced by the up sampler's ready. Produces row and frame framing flags for the up sampler, and reports overflow and frame completion.

## Interface
- IMG_W, 320, pixels per row (≥2)
- IMG_H, 240, rows per frame (≥1)
- FIFO_DEPTH, 1024, FIFO capacity in pixels (≥ IMG_W)
- OCC_W, 11, occupancy counter width; must hold FIFO_DEPTH
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a frame; ignored unless IDLE
- wr_valid  in  1  FIFO write strobe, the same signal driving FIFO wr_en
- fifo_empty  in  1  FIFO empty flag
- fifo_valid  in  1  FIFO read-data valid; arrives 1 cycle after rd_en
- up_ready  in  1  up sampler can accept a read this cycle
- rd_en  out  1  FIFO read enable (rd_en_up)
- pix_valid  out  1  pixel on FIFO dout is valid for the up sampler (= fifo_valid)
- sol, eol  out  1  with pix_valid: first / last pixel of a row
- sof, eof  out  1  with pix_valid: first / last pixel of the frame
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at frame completion
- overflow  out  1  sticky; write seen while occupancy == FIFO_DEPTH
- occupancy  out  OCC_W  scheduler's count of pixels held in the FIFO

## Operation
- States: IDLE, WAIT_ROW, BURST, DRAIN, DONE.
- IDLE: on start, clear row, issued, returned and overflow, then go to WAIT_ROW. Occupancy is not cleared.
- WAIT_ROW: when occupancy ≥ IMG_W, go to BURST on the next edge.
- BURST: rd_en = up_ready & ~fifo_empty (combinational).
  - Each rd_en increments issued.
  - When issued reaches IMG_W-1 and rd_en is high, go to DRAIN. No rd_en is ever issued in DRAIN.
- DRAIN: wait until returned == IMG_W. Then clear issued and returned, and increment row.
  - If row was IMG_H-1, go to DONE; otherwise go to WAIT_ROW.
- DONE: done = 1 for exactly one cycle, then go to IDLE.
- returned counts pix_valid cycles within a row; it wraps to 0 at row end.
- Framing flags:
  - sol = pix_valid & (returned == 0)
  - eol = pix_valid & (returned == IMG_W-1)
  - sof = sol & (row == 0)
  - eof = eol & (row == IMG_H-1)
- Occupancy (counts writes in any state, including IDLE):
  - +1 on an accepted write (wr_valid & occupancy < FIFO_DEPTH).
  - −1 on rd_en.
  - Accepted write and rd_en in the same cycle: unchanged.
  - wr_valid at occupancy == FIFO_DEPTH: occupancy unchanged; overflow set and held until the next accepted start.
- Never decrements below 0: rd_en is gated by fifo_empty.
- Counter widths: issued and returned use $clog2(IMG_W) bits; row uses $clog2(IMG_H) bits; no arithmetic wraps silently except returned at row end.

## Timing
- On reset assertion (asynchronous, any state, mid-burst included):
  - state = IDLE; all counters = 0; overflow = 0; done = 0.
  - rd_en, pix_valid, sol, eol, sof, eof = 0 (fifo_valid is expected low while in reset).
- start → busy high on the next cycle.
- WAIT_ROW to first rd_en: 1 cycle after occupancy ≥ IMG_W is visible (registered state change).
- rd_en → pix_valid: 1 cycle (FIFO read latency).
- With up_ready held high, a row produces IMG_W back-to-back rd_en pulses.
- Row-to-row gap is ≥ 2 cycles (DRAIN, then WAIT_ROW).
- up_ready low in BURST: rd_en low and the state holds. No pixel is lost.
- fifo_empty in BURST (cannot occur when entry requires a full row, but must be safe): rd_en low and the state holds.
- start during busy: no effect. start in the same cycle as the DONE→IDLE transition: ignored.

## Test plan
Parameters: IMG_W=4, IMG_H=2, FIFO_DEPTH=8.
- Reset: hold rst=0 for 3 cycles with wr_valid=1 → every output 0, occupancy 0, state IDLE. Release rst → occupancy increments by 1 per cycle.
- Full frame: write 8 pixels, pulse start, up_ready=1.
  - rd_en is high in two bursts of 4 cycles.
  - sof on pixel 0, eol on pixels 3 and 7, eof on pixel 7.
  - done pulses once; occupancy returns to 0.
- Backpressure: toggle up_ready 1,0,1,0 during BURST → exactly 4 rd_en per row, and pix_valid count equals rd_en count.
- Late data: start with only 3 pixels written → no rd_en. The 4th write → first rd_en exactly 2 cycles after that write.
- Overflow: write 9 pixels with no reads → occupancy saturates at 8 and overflow=1. A following start (idle) → overflow=0.
- Reset mid-frame: assert rst after 2 rd_en in row 0 → outputs 0 immediately (asynchronous). After release, start is accepted and row counting restarts at 0.

Source files
------------

// File: rtl/gaussian_row_scheduler.sv
// Read-side scheduler for the Gaussian stage FIFO: waits for a full row, then
// bursts one row of reads to the up sampler and frames the returned pixels.
module gaussian_row_scheduler #(
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int FIFO_DEPTH = 1024,
    parameter int OCC_W      = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             wr_valid,
    input  logic             fifo_empty,
    input  logic             fifo_valid,
    input  logic             up_ready,
    output logic             rd_en,
    output logic             pix_valid,
    output logic             sol,
    output logic             eol,
    output logic             sof,
    output logic             eof,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [OCC_W-1:0] occupancy
);

    localparam int PIX_W = $clog2(IMG_W);
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);
    localparam logic [OCC_W-1:0] DEPTH    = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] ROW_PIX  = OCC_W'(IMG_W);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ROW,
        BURST,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [PIX_W-1:0] issued;
    logic [PIX_W-1:0] returned;
    logic [ROW_W-1:0] row;
    logic             row_returned;
    logic             start_ok;
    logic             wr_accept;
    logic             rd_req;
    logic             drain_exit;

    assign start_ok   = (state == IDLE) && start;
    assign wr_accept  = wr_valid && (occupancy < DEPTH);
    assign rd_req     = up_ready && !fifo_empty;
    assign drain_exit = (state == DRAIN) && row_returned;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_next = WAIT_ROW;
            end
            WAIT_ROW: begin
                if (occupancy >= ROW_PIX) state_next = BURST;
            end
            BURST: begin
                rd_en = rd_req;
                if (rd_req && (issued == LAST_PIX)) state_next = DRAIN;
            end
            DRAIN: begin
                if (row_returned) state_next = (row == LAST_ROW) ? DONE : WAIT_ROW;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign pix_valid = fifo_valid;
    assign sol       = pix_valid && (returned == '0);
    assign eol       = pix_valid && (returned == LAST_PIX);
    assign sof       = sol && (row == '0);
    assign eof       = eol && (row == LAST_ROW);

    // returned wraps at row end, so row_returned remembers that the last pixel came back
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued       <= '0;
            returned     <= '0;
            row          <= '0;
            row_returned <= 1'b0;
        end else if (start_ok) begin
            issued       <= '0;
            returned     <= '0;
            row          <= '0;
            row_returned <= 1'b0;
        end else begin
            if (rd_en && (issued != LAST_PIX)) issued <= issued + 1'b1;
            if (pix_valid) begin
                if (returned == LAST_PIX) begin
                    returned     <= '0;
                    row_returned <= 1'b1;
                end else begin
                    returned <= returned + 1'b1;
                end
            end
            if (drain_exit) begin
                issued       <= '0;
                returned     <= '0;
                row_returned <= 1'b0;
                if (row != LAST_ROW) row <= row + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occupancy <= '0;
            overflow  <= 1'b0;
        end else begin
            if (wr_accept && !rd_en) begin
                occupancy <= occupancy + 1'b1;
            end else if (!wr_accept && rd_en) begin
                occupancy <= occupancy - 1'b1;
            end
            if (start_ok) begin
                overflow <= 1'b0;
            end else if (wr_valid && (occupancy == DEPTH)) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gaussian_row_scheduler.sv
// Bench for gaussian_row_scheduler: FIFO model plus frame-position model of the
// framing flags, driven by directed steps with randomized ready/write patterns.
module tb_gaussian_row_scheduler;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int D  = 8;
    localparam int OW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          wr_valid;
    logic          fifo_empty;
    logic          fifo_valid;
    logic          up_ready;
    logic          rd_en;
    logic          pix_valid;
    logic          sol;
    logic          eol;
    logic          sof;
    logic          eof;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [OW-1:0] occupancy;

    int   fifo_cnt;
    int   checks       = 0;
    int   passed       = 0;
    int   cyc          = 0;
    int   pix_idx      = 0;
    int   rd_total     = 0;
    int   rd_runs      = 0;
    int   done_total   = 0;
    int   wr_total     = 0;
    int   first_rd_cyc = -1;
    logic prev_rd      = 1'b0;

    always #5 clk = ~clk;

    gaussian_row_scheduler #(
        .IMG_W     (W),
        .IMG_H     (H),
        .FIFO_DEPTH(D),
        .OCC_W     (OW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .wr_valid  (wr_valid),
        .fifo_empty(fifo_empty),
        .fifo_valid(fifo_valid),
        .up_ready  (up_ready),
        .rd_en     (rd_en),
        .pix_valid (pix_valid),
        .sol       (sol),
        .eol       (eol),
        .sof       (sof),
        .eof       (eof),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .occupancy (occupancy)
    );

    // Behavioural FIFO: drops writes when full, returns data one cycle after a read
    assign fifo_empty = (fifo_cnt == 0);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_cnt   <= 0;
            fifo_valid <= 1'b0;
        end else begin
            fifo_valid <= rd_en;
            fifo_cnt   <= fifo_cnt + ((wr_valid && fifo_cnt < D) ? 1 : 0) - (rd_en ? 1 : 0);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic sampleCycle();
        logic [3:0] exp_flags;
        checkOutput("occupancy", 32'(occupancy), 32'(fifo_cnt));
        checkOutput("rd_gated", 32'(rd_en & fifo_empty), 32'd0);
        if (rd_en === 1'b1) begin
            rd_total++;
            if (!prev_rd) rd_runs++;
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
        end
        prev_rd = (rd_en === 1'b1);
        if (done === 1'b1) done_total++;
        if (pix_valid === 1'b1) begin
            exp_flags = {(pix_idx % W) == 0, (pix_idx % W) == (W - 1),
                         pix_idx == 0, pix_idx == (W * H - 1)};
            checkOutput("framing", 32'({sol, eol, sof, eof}), 32'(exp_flags));
            if ((pix_idx % W) == (W - 1)) checkOutput("rd_per_row", 32'(rd_total), 32'(pix_idx + 1));
            pix_idx++;
        end else begin
            checkOutput("flags_idle", 32'({sol, eol, sof, eof}), 32'd0);
        end
    endtask

    task automatic applyStimulus(input logic w, input logic r, input logic s);
        wr_valid = w;
        up_ready = r;
        start    = s;
        if (w) wr_total++;
        @(negedge clk);
        sampleCycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic doReset();
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        rst      = 1'b1;
        wr_total = 0;
    endtask

    task automatic writePixels(input int n);
        repeat (n) applyStimulus(1'b1, 1'b0, 1'b0);
    endtask

    task automatic startPulse(input logic r);
        pix_idx      = 0;
        rd_total     = 0;
        rd_runs      = 0;
        first_rd_cyc = -1;
        prev_rd      = 1'b0;
        applyStimulus(1'b0, r, 1'b1);
        checkOutput("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic finishFrame(input int wr_goal, input int max_cycles, input bit rand_ready, input int poke);
        int   n  = 0;
        int   d0 = done_total;
        logic w;
        logic r;
        while (done_total == d0 && n < max_cycles) begin
            w = (wr_total < wr_goal) && ($urandom_range(0, 1) == 1);
            r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            applyStimulus(w, r, 1'(n == poke));
            n++;
        end
        checkOutput("frame_done", 32'(done_total - d0), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("done_once", 32'(done_total - d0), 32'd1);
        checkOutput("frame_reads", 32'(rd_total), 32'(W * H));
        checkOutput("frame_pixels", 32'(pix_idx), 32'(W * H));
        checkOutput("busy_after_done", 32'(busy), 32'd0);
        checkOutput("occ_after_frame", 32'(occupancy), 32'(wr_goal - W * H));
    endtask

    initial begin
        int n;
        int t_write;
        rst      = 1'b1;
        start    = 1'b0;
        wr_valid = 1'b0;
        up_ready = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] reset behaviour");
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("reset_outputs", 32'({rd_en, pix_valid, sol, eol, sof, eof, busy, done, overflow}), 32'd0);
        checkOutput("reset_occ", 32'(occupancy), 32'd0);
        rst      = 1'b1;
        wr_total = 0;
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("occ_release_1", 32'(occupancy), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("occ_release_2", 32'(occupancy), 32'd2);

        $display("[TB] full frame");
        doReset();
        writePixels(8);
        checkOutput("occ_full", 32'(occupancy), 32'd8);
        startPulse(1'b1);
        finishFrame(8, 60, 1'b0, -1);
        checkOutput("burst_runs", 32'(rd_runs), 32'd2);

        $display("[TB] backpressure with random writes and a start while busy");
        doReset();
        writePixels(4);
        startPulse(1'b1);
        finishFrame(8, 400, 1'b1, 6);

        $display("[TB] late data");
        doReset();
        writePixels(3);
        startPulse(1'b1);
        repeat (5) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("no_rd_before_row", 32'(rd_total), 32'd0);
        t_write = cyc;
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("late_first_rd", 32'(first_rd_cyc - t_write), 32'd2);
        finishFrame(8, 100, 1'b0, -1);

        $display("[TB] overflow");
        doReset();
        writePixels(8);
        checkOutput("no_overflow_at_depth", 32'(overflow), 32'd0);
        writePixels(1);
        checkOutput("occ_saturated", 32'(occupancy), 32'd8);
        checkOutput("overflow_set", 32'(overflow), 32'd1);
        startPulse(1'b0);
        checkOutput("overflow_cleared", 32'(overflow), 32'd0);

        $display("[TB] reset mid-frame");
        doReset();
        writePixels(8);
        startPulse(1'b1);
        n = 0;
        while (rd_total < 2 && n < 20) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            n++;
        end
        checkOutput("two_reads", 32'(rd_total), 32'd2);
        checkOutput("rd_before_reset", 32'(rd_en), 32'd1);
        rst = 1'b0;
        #1;
        checkOutput("async_reset_outputs", 32'({rd_en, pix_valid, sol, eol, sof, eof, busy, done, overflow}), 32'd0);
        checkOutput("async_reset_occ", 32'(occupancy), 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        wr_total = 0;
        writePixels(8);
        startPulse(1'b1);
        finishFrame(8, 60, 1'b0, -1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
